simd_sobel_mag_collect: RTL and testbench

- Downstream consumer of the FOUR12 SIMD DSP48E1 adder in the Sobel path.
- Tracks in-flight operand issues through the fixed DSP pipeline, because the DSP has no valid signal.
- Captures the 48-bit P result and splits it into four signed 12-bit lanes (two Gx/Gy pairs). Computes saturated |Gx|+|Gy| magnitudes, two 8-bit pixels per beat.
- Buffers results in a FIFO with a valid/ready output. Throttles the issuer by credit, since the DSP cannot stall.

---
 rtl/sobel_pkg.sv | 57 +++++
 rtl/sync_fifo_fwft.sv | 58 +++++
 rtl/simd_sobel_mag_collect.sv | 110 +++++++++++
 tb/tb_simd_sobel_mag_collect.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared lane/pixel definitions for the Sobel SIMD path and the per-pixel
// |Gx|+|Gy| magnitude helper used by the collector.
package sobel_pkg;

  localparam int unsigned LANE_W    = 12;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned P_W       = NUM_LANES * LANE_W;
  localparam int unsigned SUM_W     = LANE_W + 1;

  localparam int unsigned LANE_GX0 = 0;
  localparam int unsigned LANE_GY0 = 1;
  localparam int unsigned LANE_GX1 = 2;
  localparam int unsigned LANE_GY1 = 3;

  localparam logic [PIX_W-1:0]  MAG_MAX  = 8'hFF;
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};

  typedef struct packed {
    logic [PIX_W-1:0] pix1;
    logic [PIX_W-1:0] pix0;
  } beat_t;

  // Absolute value of a signed lane; the most negative code clamps to the max positive.
  function automatic logic [LANE_W-1:0] lane_abs(input logic [LANE_W-1:0] v);
    logic [LANE_W-1:0] r;
    if (v == LANE_MIN) begin
      r = LANE_MAX;
    end else if (v[LANE_W-1]) begin
      r = ~v + LANE_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [PIX_W-1:0] pix_mag(
    input logic [LANE_W-1:0] gx,
    input logic [LANE_W-1:0] gy,
    input int unsigned       shift,
    input logic              thr_en,
    input logic [PIX_W-1:0]  thr
  );
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] s;
    logic [PIX_W-1:0] mag;
    sum = SUM_W'(lane_abs(gx)) + SUM_W'(lane_abs(gy));
    s   = sum >> shift;
    mag = (s > SUM_W'(MAG_MAX)) ? MAG_MAX : s[PIX_W-1:0];
    if (thr_en) begin
      mag = (mag >= thr) ? MAG_MAX : '0;
    end
    return mag;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a registered head (valid/data)
// and an occupancy count. Data holds its last value while the FIFO is empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt_c;
  logic             pop_c;
  logic [CW-1:0]    remain_c;

  assign pop_c        = pop & valid;
  assign rd_ptr_nxt_c = rd_ptr + AW'(pop_c);
  assign remain_c     = count - CW'(pop_c);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Head register: next entry from storage if one remains, else the word being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      data   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_nxt_c;
      count  <= remain_c + CW'(push);
      valid  <= (remain_c != '0) | push;
      if (remain_c != '0) begin
        data <= mem[rd_ptr_nxt_c];
      end else if (push) begin
        data <= push_data;
      end
    end
  end

endmodule

// File: rtl/simd_sobel_mag_collect.sv
// Collects FOUR12 SIMD DSP results: tracks issues through the fixed DSP latency,
// computes two saturated |Gx|+|Gy| pixels per beat and throttles the issuer by credit.
module simd_sobel_mag_collect
  import sobel_pkg::*;
#(
  parameter int unsigned DSP_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [P_W-1:0]       dsp_p_i,
  input  logic [NUM_LANES-1:0] dsp_carryout_i,
  input  logic                 thresh_en_i,
  input  logic [PIX_W-1:0]     thresh_i,
  input  logic                 clear_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [2*PIX_W-1:0]   m_data_o,
  output logic                 ovf_sticky_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CR_W  = CNT_W + 1;

  logic [DSP_LAT-1:0] vld_sr;
  logic               accept_c;
  logic               tap_c;
  logic               push_c;
  logic               pop_c;

  logic               cap_v;
  logic               cap_carry;
  logic [P_W-1:0]     cap_p;
  beat_t              wr_beat_c;

  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_nxt_c;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   inflight_nxt_c;
  logic [CR_W-1:0]    credit_nxt_c;

  assign accept_c = issue_valid_i & issue_ready_o;
  assign tap_c    = vld_sr[DSP_LAT-1];
  assign push_c   = cap_v;
  assign pop_c    = m_valid_o & m_ready_i;

  // Credit covers both queued beats and results still inside the DSP/stage pipeline.
  assign count_nxt_c    = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
  assign inflight_nxt_c = inflight + CNT_W'(accept_c) - CNT_W'(push_c);
  assign credit_nxt_c   = CR_W'(count_nxt_c) + CR_W'(inflight_nxt_c);

  // Stage 2: magnitude of the captured word; the FIFO storage acts as its register.
  always_comb begin
    wr_beat_c      = '0;
    wr_beat_c.pix0 = pix_mag(cap_p[LANE_GX0*LANE_W +: LANE_W],
                             cap_p[LANE_GY0*LANE_W +: LANE_W],
                             SHIFT, thresh_en_i, thresh_i);
    wr_beat_c.pix1 = pix_mag(cap_p[LANE_GX1*LANE_W +: LANE_W],
                             cap_p[LANE_GY1*LANE_W +: LANE_W],
                             SHIFT, thresh_en_i, thresh_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_sr        <= '0;
      cap_v         <= 1'b0;
      cap_carry     <= 1'b0;
      cap_p         <= '0;
      inflight      <= '0;
      issue_ready_o <= 1'b0;
      ovf_sticky_o  <= 1'b0;
    end else begin
      vld_sr[0] <= accept_c;
      for (int i = 1; i < int'(DSP_LAT); i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      cap_v <= tap_c;
      if (tap_c) begin
        cap_p     <= dsp_p_i;
        cap_carry <= |dsp_carryout_i;
      end
      inflight      <= inflight_nxt_c;
      issue_ready_o <= (credit_nxt_c < CR_W'(FIFO_DEPTH));
      // A fresh carry-out beats a simultaneous clear.
      if (cap_v && cap_carry) begin
        ovf_sticky_o <= 1'b1;
      end else if (clear_i) begin
        ovf_sticky_o <= 1'b0;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (push_c),
    .push_data (wr_beat_c),
    .pop       (pop_c),
    .valid     (m_valid_o),
    .data      (m_data_o),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_simd_sobel_mag_collect.sv
// Randomised and directed bench for simd_sobel_mag_collect, with a DSP pipeline
// model driving dsp_p_i and a queue-based scoreboard of expected pixels.
module tb_simd_sobel_mag_collect;

  localparam int DSP_LAT = 3;
  localparam int DEPTH   = 8;
  localparam int SHIFT   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [47:0] dsp_p = '0;
  logic [3:0]  dsp_c = '0;
  logic        thresh_en = 1'b0;
  logic [7:0]  thresh = '0;
  logic        clear = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        ovf;

  always #5 clk = ~clk;

  simd_sobel_mag_collect #(
    .DSP_LAT    (DSP_LAT),
    .FIFO_DEPTH (DEPTH),
    .SHIFT      (SHIFT)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .dsp_p_i        (dsp_p),
    .dsp_carryout_i (dsp_c),
    .thresh_en_i    (thresh_en),
    .thresh_i       (thresh),
    .clear_i        (clear),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
    .ovf_sticky_o   (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference pixel: plain integer arithmetic on the signed lane values.
  function automatic int abs12(input logic [11:0] v);
    int s;
    s = (v >= 12'h800) ? int'(v) - 4096 : int'(v);
    if (s < 0) s = -s;
    if (s > 2047) s = 2047;
    return s;
  endfunction

  function automatic logic [7:0] pix(input logic [11:0] gx, input logic [11:0] gy,
                                     input logic te, input logic [7:0] th);
    int m;
    m = (abs12(gx) + abs12(gy)) >>> SHIFT;
    if (m > 255) m = 255;
    if (te) m = (m >= int'(th)) ? 255 : 0;
    return 8'(m);
  endfunction

  function automatic logic [11:0] rlane();
    case ($urandom % 8)
      0:       return 12'h800;
      1:       return 12'h7FF;
      2:       return 12'h000;
      3:       return 12'(0 - $urandom_range(0, 200));
      4:       return 12'($urandom_range(0, 200));
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [47:0] rpay();
    return {rlane(), rlane(), rlane(), rlane()};
  endfunction

  // Operands presented with issue_valid, and the scoreboard state.
  logic [47:0] iss_p = '0;
  logic [3:0]  iss_c = '0;
  logic        acc_d = 1'b0;
  logic [47:0] acc_p = '0;
  logic [3:0]  acc_c = '0;
  logic [15:0] exp_q[$];
  int          outstanding = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  bit          up = 1'b0;
  bit          sticky_exp = 1'b0;

  always @(posedge clk) begin
    logic acc;
    logic pop;
    logic [15:0] e;
    acc_d = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0;
      up = 1'b0;
      sticky_exp = 1'b0;
    end else begin
      check("issue_ready", issue_ready, (up && outstanding < DEPTH));
      acc = issue_valid && issue_ready;
      pop = m_valid && m_ready;
      if (pop) begin
        check("beat_present", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e);
        end
        n_pop++;
      end
      if (acc) begin
        exp_q.push_back({pix(iss_p[35:24], iss_p[47:36], thresh_en, thresh),
                         pix(iss_p[11:0],  iss_p[23:12], thresh_en, thresh)});
        n_acc++;
        if (iss_c != 4'b0) sticky_exp = 1'b1;
        acc_d = 1'b1;
        acc_p = iss_p;
        acc_c = iss_c;
      end
      outstanding = outstanding + int'(acc) - int'(pop);
      check("credit_bound", outstanding <= DEPTH, 1);
      up = 1'b1;
    end
  end

  // DSP model: fixed latency, computes on whatever is presented, no valid.
  logic [47:0] pipe_p [DSP_LAT];
  logic [3:0]  pipe_c [DSP_LAT];
  initial for (int i = 0; i < DSP_LAT; i++) begin pipe_p[i] = '0; pipe_c[i] = '0; end

  always @(negedge clk) begin
    for (int i = DSP_LAT - 1; i > 0; i--) begin
      pipe_p[i] = pipe_p[i-1];
      pipe_c[i] = pipe_c[i-1];
    end
    if (acc_d) begin
      pipe_p[0] = acc_p;
      pipe_c[0] = acc_c;
    end else begin
      pipe_p[0] = {16'($urandom), 32'($urandom)};
      pipe_c[0] = 4'($urandom);
    end
    dsp_p = pipe_p[DSP_LAT-1];
    dsp_c = pipe_c[DSP_LAT-1];
  end

  task automatic issue_one(input logic [47:0] p, input logic [3:0] c);
    int g;
    g = 0;
    @(negedge clk);
    while (!issue_ready && g < 100) begin @(negedge clk); g++; end
    check("issue_wait_bound", g >= 100, 0);
    iss_p = p;
    iss_c = c;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    iss_c = 4'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] exp);
    int g;
    g = 0;
    while (!m_valid && g < 20) begin @(negedge clk); g++; end
    check({tag, "_timeout"}, g >= 20, 0);
    check(tag, m_data, exp);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while (outstanding != 0 && g < 200) begin @(negedge clk); g++; end
    check(tag, outstanding, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sticky_exp = 1'b0;
    check("clear_sticky", ovf, 0);
  endtask

  task automatic rand_phase(input int cycles, input logic te, input logic [7:0] th);
    @(negedge clk);
    thresh_en = te;
    thresh = th;
    for (int i = 0; i < cycles; i++) begin
      issue_valid = ($urandom % 4) != 0;
      iss_p = rpay();
      iss_c = (($urandom % 8) == 0) ? 4'($urandom) : 4'b0;
      m_ready = ($urandom % 3) != 0;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    iss_c = 4'b0;
    m_ready = 1'b1;
    wait_drain("rand_drain");
    repeat (3) @(negedge clk);
    check("rand_sticky", ovf, sticky_exp);
    pulse_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int start;
    int pstart;
    int g;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", issue_ready, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", issue_ready, 1);

    // Single issue: latency and value.
    issue_one(48'h000_000_FCE_064, 4'b0);
    for (int k = 1; k <= 7; k++) begin
      check("lat_valid", m_valid, k == 5);
      if (k == 5) check("single_data", m_data, 16'h0096);
      @(negedge clk);
    end

    // Saturation, including the most negative lane.
    issue_one(48'h001_800_3FC_3FC, 4'b0);
    expect_beat("sat_data", 16'hFFFF);

    // Threshold, including the equal-to-threshold boundary.
    wait_drain("pre_thresh_drain");
    thresh_en = 1'b1;
    thresh = 8'h80;
    issue_one(48'hFCE_032_FCE_064, 4'b0);
    expect_beat("thresh_data", 16'h00FF);
    issue_one(48'h000_080_000_07F, 4'b0);
    expect_beat("thresh_edge", 16'hFF00);
    wait_drain("thresh_drain");
    thresh_en = 1'b0;

    // Sticky overflow timing, set-wins and plain clear.
    issue_one(48'h000_000_000_001, 4'b0100);
    for (int k = 1; k <= 6; k++) begin
      check("ovf_timing", ovf, k >= 5);
      @(negedge clk);
    end
    issue_one(48'h000_000_000_002, 4'b0001);
    for (int k = 1; k <= 5; k++) begin
      clear = (k == 4);
      if (k == 5) check("ovf_set_wins", ovf, 1);
      @(negedge clk);
    end
    clear = 1'b0;
    pulse_clear();
    issue_one(48'h000_000_000_003, 4'b1000);
    wait_drain("sticky_drain");
    @(negedge clk);
    check("ovf_reset_again", ovf, 1);

    // Backpressure: credit stops issues at FIFO_DEPTH, then all beats drain in order.
    m_ready = 1'b0;
    start = n_acc;
    pstart = n_pop;
    @(negedge clk);
    issue_valid = 1'b1;
    iss_p = rpay();
    g = 0;
    while (issue_ready && g < 40) begin @(negedge clk); iss_p = rpay(); g++; end
    issue_valid = 1'b0;
    check("bp_accepts", n_acc - start, DEPTH);
    repeat (10) @(negedge clk);
    check("bp_full_valid", m_valid, 1);
    check("bp_ready_low", issue_ready, 0);
    check("bp_hold", m_data, (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx);
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_reassert", issue_ready, 1);
    wait_drain("bp_drain");
    check("bp_pops", n_pop - pstart, DEPTH);

    // Reset with three results in flight.
    @(negedge clk);
    issue_valid = 1'b1;
    iss_p = rpay();
    @(negedge clk);
    iss_p = rpay();
    @(negedge clk);
    iss_p = rpay();
    @(negedge clk);
    issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", issue_ready, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_up", issue_ready, 1);
    for (int k = 0; k < 10; k++) begin
      check("mid_rst_no_stale", m_valid, 0);
      @(negedge clk);
    end

    // Randomised traffic against the scoreboard.
    rand_phase(800, 1'b0, 8'h00);
    rand_phase(600, 1'b1, 8'($urandom_range(1, 254)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
